// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a saturating backpressure-stall counter.
module pipe_skid_reg #(
  parameter int          WIDTH   = 64,
  parameter int unsigned SKID_EN = 1,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             stateQ, stateD;
  logic [WIDTH-1:0]   mainData, skidData;
  logic [CNT_W-1:0]   stallCnt;
  logic               mainV, skidV;
  logic               inFire, outFire;

  assign mainV   = (stateQ != EMPTY);
  assign skidV   = (stateQ == SKID);
  assign inFire  = in_valid & in_ready & ~flush;
  assign outFire = mainV & out_ready;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= EMPTY;
    else     stateQ <= stateD;
  end

  // Next-state logic; flush outranks every handshake.
  // NOTE: stateD gets a default before any branch so no latch is inferred.
  always_comb begin
    stateD = stateQ;
    if (flush) begin
      stateD = EMPTY;
    end else begin
      unique case (stateQ)
        EMPTY: if (inFire) stateD = FULL;
        FULL: begin
          if (inFire && !outFire && SKID_EN != 0) stateD = SKID;
          else if (!inFire && outFire)            stateD = EMPTY;
        end
        SKID:    if (outFire) stateD = FULL;
        default: stateD = EMPTY;
      endcase
    end
  end

  // Payload storage.
  // NOTE: payload registers are reset (not just their valid bits) because
  // out_data must read zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mainData <= '0;
      skidData <= '0;
    end else begin
      unique case (stateQ)
        EMPTY: if (inFire) mainData <= in_data;
        FULL: begin
          if (inFire && (outFire || SKID_EN == 0)) mainData <= in_data;
          else if (inFire)                         skidData <= in_data;
          else if (outFire)                        mainData <= '0;
        end
        SKID: begin
          if (outFire) begin
            mainData <= skidData;
            skidData <= '0;
          end
        end
        default: mainData <= '0;
      endcase
    end
  end

  // Stall counter survives flush; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                                   stallCnt <= '0;
    else if (mainV && !out_ready && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end

  // Outputs: all registered except in_ready.
  always_comb begin
    out_valid = mainV;
    out_data  = mainData;
    occupancy = 2'(mainV) + 2'(skidV);
    stall_cnt = stallCnt;
    if (SKID_EN != 0) in_ready = ~skidV & ~flush & ~rst;
    else              in_ready = (~mainV | out_ready) & ~flush & ~rst;
  end

endmodule
